nap_read_fetch_engine: RTL
==========================

Name: nap_read_fetch_engine

Overview:
- Read-request generator and data collector directly upstream of the read-only NAP initiator wrapper; drives the AXI4 AR channel and consumes the R channel.
- Accepts a (start address, beat count) command and splits it into INCR bursts of at most MAX_BURST_LEN beats, with bounded outstanding bursts.
- Forwards returned beats in order on a valid/ready stream.
- Flags response errors and signals completion.

Parameters:
ADDR_W, 42, AXI address width (NAP consumes [27:0])
DATA_W, 256, AXI data width; bytes per beat BPB = DATA_W/8
ID_W, 8, AXI ID width
ARID_VAL, 0, constant arid
MAX_BURST_LEN, 16, max beats per burst (1..256)
MAX_OUTSTANDING, 4, max in-flight bursts (1..15)
CNT_W, 16, beat-count width of a command

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous active-high reset
i_cmd_valid  in  1  command valid
o_cmd_ready  out  1  engine idle, command accepted when valid&ready
i_cmd_addr  in  ADDR_W  start byte address, BPB-aligned
i_cmd_beats  in  CNT_W  total beats to fetch
o_arvalid  out  1  AR valid
i_arready  in  1  AR ready
o_araddr  out  ADDR_W  burst address
o_arlen  out  8  beats-1
o_arsize  out  3  log2(BPB)
o_arburst  out  2  constant 2'b01 (INCR)
o_arid  out  ID_W  constant ARID_VAL
o_arqos  out  4  constant 0
i_rvalid  in  1  R valid
o_rready  out  1  R ready (= i_out_ready while busy)
i_rdata  in  DATA_W  read data
i_rresp  in  2  read response
i_rlast  in  1  last beat of burst
i_rid  in  ID_W  read ID (ignored)
o_out_valid  out  1  output beat valid
i_out_ready  in  1  downstream ready
o_out_data  out  DATA_W  output beat
o_out_last  out  1  final beat of the command
o_done  out  1  one-cycle pulse, command complete
o_error  out  1  sticky error flag, cleared on next command accept
o_busy  out  1  state != IDLE

Behaviour:
- Reset: state IDLE, o_cmd_ready=1, o_arvalid=0, o_rready=0, o_out_valid=0, o_done=0, o_error=0, o_busy=0, all counters 0.
- States: IDLE -> ISSUE on cmd accept with beats>0. ISSUE -> DRAIN when all bursts are issued. DRAIN -> DONE when beats_received == total. DONE -> IDLE after one cycle; o_done=1 during DONE.
- cmd accepted with beats==0: IDLE -> DONE directly, no AR issued, o_done pulses 1 cycle after accept.
- Burst sizing: len = min(remaining_to_issue, MAX_BURST_LEN); o_arlen = len-1.
- Addresses: next araddr = araddr + len*BPB; wraps modulo 2^ADDR_W. No 4 KB split is performed, so the caller aligns addresses.
- AR issue: o_arvalid asserts in ISSUE only while outstanding < MAX_OUTSTANDING. araddr/arlen are held stable while arvalid=1 and arready=0.
- Outstanding counter: +1 on AR handshake, -1 on R handshake with rlast. Both in the same cycle leave it unchanged.
- R path: o_rready = i_out_ready in ISSUE/DRAIN, else 0. Output is combinational pass-through: o_out_valid = i_rvalid & busy, o_out_data = i_rdata. Zero added latency; rdata is never dropped.
- o_out_last = 1 on the beat where beats_received == total-1.
- Errors, each sets o_error (sticky):
  - rresp != 2'b00 on any beat.
  - rlast asserted on a beat other than the expected burst end.
  - rlast missing on the expected burst end.
  - Data continues to be forwarded after an error.
- R beats arriving in IDLE are not accepted (rready=0).
- i_reset mid-operation: returns to reset values next cycle; in-flight responses are not tracked.

Optional Feature:
- Macro: NAP_FETCH_PERF_CNT_EN.
- When defined, adds two extra outputs:
  - o_perf_cycles [31:0]: cycles from cmd accept to o_done, inclusive, latched at DONE.
  - o_perf_stall [31:0]: cycles in ISSUE/DRAIN with i_rvalid=1 & i_out_ready=0.
  - Both clear on reset and on cmd accept.
- When undefined, these ports and counters do not exist.

Test Plan:
- addr=0x1000, beats=40, MAX_BURST_LEN=16, arready/out_ready=1:
  - ARs (0x1000,len15), (0x1200,len15), (0x1400,len7).
  - 40 out beats in order, out_last on beat 40, o_done 1 pulse, o_error=0.
- beats=0 -> no arvalid, o_done pulses once one cycle after accept, cmd_ready returns 1.
- beats=128, MAX_OUTSTANDING=4, R withheld -> exactly 4 AR handshakes, then arvalid=0 until first rlast.
- Random arready/out_ready backpressure, beats=37:
  - araddr/arlen stable while stalled.
  - rready mirrors out_ready.
  - All 37 beats delivered intact.
- rresp=2'b10 on beat 5 -> o_error=1 persists through o_done, cleared on next cmd accept.
- Reset asserted mid-DRAIN -> next cycle all outputs at reset values; new command then completes normally.

Source files
------------

// File: rtl/nap_read_fetch_engine.sv
// Read-fetch engine: splits a (addr, beats) command into INCR AR bursts and streams R beats out.
// Optional perf counters are enabled with `define NAP_FETCH_PERF_CNT_EN.
module nap_read_fetch_engine #(
   parameter int unsigned ADDR_W          = 42,
   parameter int unsigned DATA_W          = 256,
   parameter int unsigned ID_W            = 8,
   parameter int unsigned ARID_VAL        = 0,
   parameter int unsigned MAX_BURST_LEN   = 16,
   parameter int unsigned MAX_OUTSTANDING = 4,
   parameter int unsigned CNT_W           = 16
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_cmd_valid,
   output logic              o_cmd_ready,
   input  logic [ADDR_W-1:0] i_cmd_addr,
   input  logic [CNT_W-1:0]  i_cmd_beats,
   output logic              o_arvalid,
   input  logic              i_arready,
   output logic [ADDR_W-1:0] o_araddr,
   output logic [7:0]        o_arlen,
   output logic [2:0]        o_arsize,
   output logic [1:0]        o_arburst,
   output logic [ID_W-1:0]   o_arid,
   output logic [3:0]        o_arqos,
   input  logic              i_rvalid,
   output logic              o_rready,
   input  logic [DATA_W-1:0] i_rdata,
   input  logic [1:0]        i_rresp,
   input  logic              i_rlast,
   input  logic [ID_W-1:0]   i_rid,
   output logic              o_out_valid,
   input  logic              i_out_ready,
   output logic [DATA_W-1:0] o_out_data,
   output logic              o_out_last,
   output logic              o_done,
   output logic              o_error,
   output logic              o_busy
`ifdef NAP_FETCH_PERF_CNT_EN
   ,
   output logic [31:0]       o_perf_cycles,
   output logic [31:0]       o_perf_stall
`endif
);

   localparam int unsigned BPB  = DATA_W / 8;
   localparam int unsigned SIZE = $clog2(BPB);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   logic [1:0]        r_state;
   logic [ADDR_W-1:0] r_araddr;
   logic [CNT_W-1:0]  r_issue_rem;
   logic [CNT_W-1:0]  r_total;
   logic [CNT_W-1:0]  r_rcvd;
   logic [3:0]        r_outstanding;
   logic [7:0]        r_bcnt;
   logic              r_error;

   logic       w_active;
   logic       w_cmd_hs;
   logic       w_ar_hs;
   logic       w_r_hs;
   logic       w_rlast_hs;
   logic       w_exp_end;
   logic [8:0] w_len;
   logic       w_unused_rid;

   assign w_unused_rid = ^i_rid;

   assign w_active   = (r_state == ST_ISSUE) || (r_state == ST_DRAIN);
   assign w_cmd_hs   = i_cmd_valid && (r_state == ST_IDLE);
   assign w_len      = (r_issue_rem >= CNT_W'(MAX_BURST_LEN)) ? 9'(MAX_BURST_LEN)
                                                              : 9'(r_issue_rem);
   assign w_ar_hs    = o_arvalid && i_arready;
   assign w_r_hs     = i_rvalid && o_rready;
   assign w_rlast_hs = w_r_hs && i_rlast;

   // Bursts return in order, so the expected burst end follows from the beat position alone.
   assign w_exp_end = (r_bcnt == 8'(MAX_BURST_LEN - 1)) || (r_rcvd == r_total - CNT_W'(1));

   assign o_cmd_ready = (r_state == ST_IDLE);
   assign o_busy      = (r_state != ST_IDLE);
   assign o_done      = (r_state == ST_DONE);
   assign o_error     = r_error;

   assign o_arvalid = (r_state == ST_ISSUE) && (r_outstanding < 4'(MAX_OUTSTANDING));
   assign o_araddr  = r_araddr;
   assign o_arlen   = 8'(w_len - 9'd1);
   assign o_arsize  = 3'(SIZE);
   assign o_arburst = 2'b01;
   assign o_arid    = ID_W'(ARID_VAL);
   assign o_arqos   = 4'd0;

   assign o_rready    = w_active && i_out_ready;
   assign o_out_valid = w_active && i_rvalid;
   assign o_out_data  = i_rdata;
   assign o_out_last  = w_active && (r_rcvd == r_total - CNT_W'(1));

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state       <= ST_IDLE;
         r_araddr      <= '0;
         r_issue_rem   <= '0;
         r_total       <= '0;
         r_rcvd        <= '0;
         r_outstanding <= '0;
         r_bcnt        <= '0;
         r_error       <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_cmd_hs) begin
                  r_araddr      <= i_cmd_addr;
                  r_issue_rem   <= i_cmd_beats;
                  r_total       <= i_cmd_beats;
                  r_rcvd        <= '0;
                  r_bcnt        <= '0;
                  r_outstanding <= '0;
                  r_error       <= 1'b0;
                  r_state       <= (i_cmd_beats == '0) ? ST_DONE : ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (w_ar_hs && (r_issue_rem == CNT_W'(w_len))) begin
                  r_state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (r_rcvd == r_total) begin
                  r_state <= ST_DONE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase

         if (w_ar_hs) begin
            r_araddr    <= r_araddr + (ADDR_W'(w_len) << SIZE);
            r_issue_rem <= r_issue_rem - CNT_W'(w_len);
         end

         if (w_ar_hs && !w_rlast_hs) begin
            r_outstanding <= r_outstanding + 4'd1;
         end else if (!w_ar_hs && w_rlast_hs && (r_outstanding != 4'd0)) begin
            r_outstanding <= r_outstanding - 4'd1;
         end

         if (w_r_hs) begin
            r_rcvd <= r_rcvd + CNT_W'(1);
            r_bcnt <= w_exp_end ? 8'd0 : r_bcnt + 8'd1;
            if ((i_rresp != 2'b00) || (i_rlast != w_exp_end)) begin
               r_error <= 1'b1;
            end
         end
      end
   end

`ifdef NAP_FETCH_PERF_CNT_EN
   logic [31:0] r_perf_run;
   logic [31:0] r_perf_cycles;
   logic [31:0] r_perf_stall;

   // r_perf_run counts the accept cycle as 1; the DONE cycle itself is added on latch.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_perf_run    <= '0;
         r_perf_cycles <= '0;
         r_perf_stall  <= '0;
      end else if (w_cmd_hs) begin
         r_perf_run    <= 32'd1;
         r_perf_cycles <= '0;
         r_perf_stall  <= '0;
      end else begin
         if (r_state != ST_IDLE) begin
            r_perf_run <= r_perf_run + 32'd1;
         end
         if (r_state == ST_DONE) begin
            r_perf_cycles <= r_perf_run + 32'd1;
         end
         if (w_active && i_rvalid && !i_out_ready) begin
            r_perf_stall <= r_perf_stall + 32'd1;
         end
      end
   end

   assign o_perf_cycles = r_perf_cycles;
   assign o_perf_stall  = r_perf_stall;
`endif

endmodule
